// File: rtl/unary_window_count.sv
// Counts ones on unary bitstream lanes over a 2^WLOG enabled-cycle window.
// Optional signed output offset under `UBRAIN_WCNT_BIPOLAR_EN.
module unary_window_count #(
    parameter int IWID  = 10,
    parameter int WLOG  = 8,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             enable,
    input  logic             clear,
    input  logic [LANES-1:0] iBit,
    output logic             load,
    output logic [IWID-1:0]  oData,
    output logic             busy
);

    localparam int AW = WLOG + $clog2(LANES + 1) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [WLOG-1:0]   cyc_q, cyc_d;
    logic [IWID-1:0]   data_q, data_d;
    logic              load_q, load_d;
    logic [AW-1:0]     sum;

    function automatic logic [AW-1:0] popcnt(input logic [LANES-1:0] b);
        logic [AW-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) n = n + AW'(b[i]);
        return n;
    endfunction

`ifdef UBRAIN_WCNT_BIPOLAR_EN
    localparam int XW = AW + IWID + 1;
    localparam logic signed [XW-1:0] OFS  = XW'(LANES) <<< (WLOG - 1);
    localparam logic signed [XW-1:0] SMAX = (XW'(1) <<< (IWID - 1)) - XW'(1);
    localparam logic signed [XW-1:0] SMIN = -(XW'(1) <<< (IWID - 1));

    // Centre the count on zero, then clamp to the signed output range.
    function automatic logic [IWID-1:0] sat(input logic [AW-1:0] s);
        logic signed [XW-1:0] sx;
        sx = $signed({{(IWID + 1){1'b0}}, s}) - OFS;
        if (sx > SMAX) return SMAX[IWID-1:0];
        if (sx < SMIN) return SMIN[IWID-1:0];
        return sx[IWID-1:0];
    endfunction
`else
    function automatic logic [IWID-1:0] sat(input logic [AW-1:0] s);
        logic [AW+IWID-1:0] ext;
        ext = {{IWID{1'b0}}, s};
        if (ext > {{AW{1'b0}}, {IWID{1'b1}}}) return '1;
        return ext[IWID-1:0];
    endfunction
`endif

    assign sum = acc_q + popcnt(iBit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cyc_q   <= '0;
            data_q  <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cyc_q   <= cyc_d;
            data_q  <= data_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cyc_d   = cyc_q;
        data_d  = data_q;
        load_d  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cyc_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        acc_d   = '0;
                        cyc_d   = '0;
                    end
                end
                RUN: begin
                    if (enable) begin
                        if (cyc_q == {WLOG{1'b1}}) begin
                            data_d  = sat(sum);
                            load_d  = 1'b1;
                            acc_d   = '0;
                            cyc_d   = '0;
                            state_d = start ? RUN : IDLE;
                        end else begin
                            acc_d = sum;
                            cyc_d = cyc_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign load  = load_q;
    assign oData = data_q;
    assign busy  = (state_q == RUN);

endmodule

// File: tb/tb_unary_window_count.sv
// Bench for unary_window_count: two instances (1 lane/10 bits, 2 lanes/4 bits)
// checked against a queue-based window model, directed tables and random traffic.
module tb_unary_window_count;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, enable, clear;
    logic [1:0] iBit;
    logic       load_a, busy_a, load_b, busy_b;
    logic [9:0] oData_a;
    logic [3:0] oData_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unary_window_count #(.IWID(10), .WLOG(4), .LANES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .enable(enable),
        .clear(clear), .iBit(iBit[0:0]), .load(load_a), .oData(oData_a),
        .busy(busy_a)
    );

    unary_window_count #(.IWID(4), .WLOG(4), .LANES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .enable(enable),
        .clear(clear), .iBit(iBit), .load(load_b), .oData(oData_b),
        .busy(busy_b)
    );

    localparam int W = 16;
    int lanes[2] = '{1, 2};
    int iw[2]    = '{10, 4};

    bit m_busy[2];
    bit m_load[2];
    int m_data[2];
    int m_win[2][$];

    function automatic int exp_out(int s, int d);
        int v, lim;
`ifdef UBRAIN_WCNT_BIPOLAR_EN
        v = s - lanes[d] * (W / 2);
        lim = 1 << (iw[d] - 1);
        if (v > lim - 1) v = lim - 1;
        if (v < -lim) v = -lim;
        return v & ((1 << iw[d]) - 1);
`else
        lim = (1 << iw[d]) - 1;
        v = (s > lim) ? lim : s;
        return v;
`endif
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0;
            m_load[d] = 0;
            m_data[d] = 0;
            m_win[d].delete();
        end
    endfunction

    function automatic void model_step(bit st, bit en, bit cl, logic [1:0] b);
        int p, s;
        for (int d = 0; d < 2; d++) begin
            p = (d == 0) ? int'(b[0]) : $countones(b);
            m_load[d] = 0;
            if (cl) begin
                m_busy[d] = 0;
                m_win[d].delete();
            end else if (!m_busy[d]) begin
                if (st) begin
                    m_busy[d] = 1;
                    m_win[d].delete();
                end
            end else if (en) begin
                m_win[d].push_back(p);
                if (m_win[d].size() == W) begin
                    s = 0;
                    foreach (m_win[d][k]) s += m_win[d][k];
                    m_data[d] = exp_out(s, d);
                    m_load[d] = 1;
                    m_win[d].delete();
                    m_busy[d] = st;
                end
            end
        end
    endfunction

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic check_all();
        chk("load_a", int'(load_a), int'(m_load[0]));
        chk("data_a", int'(oData_a), m_data[0]);
        chk("busy_a", int'(busy_a), int'(m_busy[0]));
        chk("load_b", int'(load_b), int'(m_load[1]));
        chk("data_b", int'(oData_b), m_data[1]);
        chk("busy_b", int'(busy_b), int'(m_busy[1]));
    endtask

    task automatic tick(bit st, bit en, bit cl, logic [1:0] b);
        start  = st;
        enable = en;
        clear  = cl;
        iBit   = b;
        model_step(st, en, cl, b);
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic logic [1:0] pat_bits(int pat, int n);
        logic [1:0] r;
        case (pat)
            1: r = 2'b11;
            2: r = {1'b0, (n % 2) == 0};
            3: r = 2'b01;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    typedef struct {
        int pat;
        int stalls;
        int lat;
        int exp_a;
        int exp_b;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int n, edges, stl, loads, last, gaps;
        bit stall;

`ifdef UBRAIN_WCNT_BIPOLAR_EN
        tbl[0] = '{1, 0, 16, 8, 7};
        tbl[1] = '{2, 5, 21, 0, 8};
        tbl[2] = '{0, 0, 16, 10'h3F8, 8};
        tbl[3] = '{3, 2, 18, 8, 0};
`else
        tbl[0] = '{1, 0, 16, 16, 15};
        tbl[1] = '{2, 5, 21, 8, 8};
        tbl[2] = '{0, 0, 16, 0, 0};
        tbl[3] = '{3, 2, 18, 16, 15};
`endif

        rst_n = 1'b0;
        start = 0; enable = 0; clear = 0; iBit = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        foreach (tbl[r]) begin
            tick(1, 0, 0, 2'b00);
            n = 0; edges = 0; stl = tbl[r].stalls; loads = 0;
            while (n < W) begin
                stall = (stl > 0) &&
                        (($urandom_range(0, 3) == 0) || (stl >= W - 1 - n));
                edges++;
                if (stall) begin
                    stl--;
                    tick(0, 0, 0, pat_bits(tbl[r].pat, n));
                end else begin
                    tick(0, 1, 0, pat_bits(tbl[r].pat, n));
                    n++;
                end
                if (load_a) loads++;
            end
            chk($sformatf("row%0d_latency", r), edges, tbl[r].lat);
            chk($sformatf("row%0d_load", r), int'(load_a), 1);
            chk($sformatf("row%0d_pulses", r), loads, 1);
            chk($sformatf("row%0d_data_a", r), int'(oData_a), tbl[r].exp_a);
            chk($sformatf("row%0d_data_b", r), int'(oData_b), tbl[r].exp_b);
            tick(0, 0, 0, 2'b00);
            chk($sformatf("row%0d_idle", r), int'(busy_a | load_a), 0);
        end

        // Abort at cyc=7, then an all-zero window.
        tick(1, 0, 0, 2'b00);
        for (int i = 0; i < 7; i++) tick(0, 1, 0, 2'b11);
        tick(0, 1, 1, 2'b11);
        loads = 0;
        for (int i = 0; i < 20; i++) begin
            tick(0, 1, 0, 2'b11);
            if (load_a) loads++;
        end
        chk("clear_no_load", loads, 0);
        tick(1, 0, 0, 2'b00);
        for (int i = 0; i < W; i++) tick(0, 1, 0, 2'b00);
        chk("zero_window_load", int'(load_a), 1);
`ifdef UBRAIN_WCNT_BIPOLAR_EN
        chk("zero_window_data", int'(oData_a), 10'h3F8);
`else
        chk("zero_window_data", int'(oData_a), 0);
`endif

        // Clear on the final sample keeps the previous oData.
        tick(1, 0, 0, 2'b00);
        for (int i = 0; i < W - 1; i++) tick(0, 1, 0, 2'b11);
        tick(0, 1, 1, 2'b11);
        chk("clear_final_load", int'(load_a), 0);
        chk("clear_final_busy", int'(busy_a), 0);

        // Back-to-back windows with start held high.
        tick(1, 0, 0, 2'b00);
        loads = 0; last = 0; gaps = 0;
        for (int i = 1; i <= 3 * W; i++) begin
            tick(1, 1, 0, 2'b11);
            if (load_a) begin
                loads++;
                if (i - last == W) gaps++;
                last = i;
`ifdef UBRAIN_WCNT_BIPOLAR_EN
                chk("b2b_data", int'(oData_a), 8);
`else
                chk("b2b_data", int'(oData_a), 16);
`endif
            end
        end
        chk("b2b_pulses", loads, 3);
        chk("b2b_spacing", gaps, 3);
        chk("b2b_still_busy", int'(busy_a), 1);
        tick(0, 0, 1, 2'b00);

        // Asynchronous reset mid-window.
        tick(1, 0, 0, 2'b00);
        for (int i = 0; i < 5; i++) tick(0, 1, 0, 2'b11);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async_data", int'(oData_a), 0);
        chk("rst_async_busy", int'(busy_a), 0);
        chk("rst_async_load", int'(load_a), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        loads = 0;
        for (int i = 0; i < 20; i++) begin
            tick(0, 1, 0, 2'b11);
            if (load_a) loads++;
        end
        chk("rst_no_load", loads, 0);

        for (int i = 0; i < 1500; i++)
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 40) == 0, 2'($urandom_range(0, 3)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
